// File: rtl/multipli_seq_param.sv
// Parametrised sequential shift-and-add multiplier, one multiplier bit per clock.
// Supports optional two's-complement operands and back-to-back issue from DONE.
module multipli_seq_param #(
  parameter int A_BITS    = 8,
  parameter int B_BITS    = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic                     CLOCK,
  input  logic                     RESET,
  input  logic                     START,
  input  logic                     SIGNED,
  input  logic [A_BITS-1:0]        A,
  input  logic [B_BITS-1:0]        B,
  output logic [A_BITS+B_BITS-1:0] S,
  output logic                     END_MULT,
  output logic                     BUSY,
  output logic [1:0]               dbg_state
);

  localparam int P  = A_BITS + B_BITS;
  localparam int CW = $clog2(B_BITS) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Handshake: START is accepted on a rising edge whenever the FSM is in IDLE
  // or DONE (BUSY=0); it is ignored in RUN. END_MULT is a one-cycle pulse in DONE.
  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [P:0]        acc;
  logic [P:0]        mcand;
  logic [B_BITS-1:0] mplier;
  logic              sgn_q;

  logic              sgn_in;
  logic [P:0]        a_ext;
  logic              last;
  logic [P:0]        addend;
  logic [P:0]        acc_nxt;

  assign sgn_in = SIGNED & SIGNED_EN;
  assign a_ext  = sgn_in ? {{(B_BITS + 1){A[A_BITS-1]}}, A}
                         : {{(B_BITS + 1){1'b0}}, A};
  assign last   = (cnt == CW'(B_BITS - 1));
  assign addend = mplier[0] ? mcand : '0;
  // The multiplier MSB carries negative weight in signed mode.
  assign acc_nxt = (sgn_q && last) ? (acc - addend) : (acc + addend);

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      sgn_q  <= 1'b0;
      S      <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (START) begin
            mcand  <= a_ext;
            mplier <= B;
            sgn_q  <= sgn_in;
            acc    <= '0;
            cnt    <= '0;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (last) begin
            S     <= acc_nxt[P-1:0];
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign END_MULT  = (state == DONE);
  assign BUSY      = (state == RUN);
  assign dbg_state = state;

endmodule
